// File: rtl/mem_ack_responder.sv
// -----------------------------------------------------------------------------
// mem_ack_responder
//
// Memory-side responder for the controller's fetch/store handshake. A level
// request (REQ) is sampled in IDLE together with WE/ADDR/WDATA. After
// WAIT_CYCLES wait states the access is performed on an internal RAM and a
// one-cycle ACK pulse is returned. That ACK is what moves the controller's
// status counter on from FF1.
//
// Handshake (REQ/ACK, the only interface protocol of this block):
//   - The controller raises REQ with WE/ADDR/WDATA valid and holds REQ high
//     until it has seen ACK.
//   - The responder captures WE/ADDR/WDATA on the first edge it sees REQ in
//     IDLE. Later changes to those inputs are ignored for that transaction.
//   - Dropping REQ at any edge during the wait states aborts the access. There
//     is no RAM write and no ACK, and RDATA is left unchanged.
//   - ACK is high for exactly one cycle. A write has been committed, or RDATA
//     holds the read word, from that cycle onward.
//   - REQ is ignored for one RECOVER cycle after ACK and is resampled only in
//     IDLE. A held REQ therefore starts a new access WAIT_CYCLES+4 cycles
//     after the previous one.
//
// Parameters
//   DATA_W      data word width
//   ADDR_W      address width, RAM depth = 2**ADDR_W words
//   WAIT_CYCLES extra wait states before ACK (0..15, checked at elaboration)
//   PROT_LIMIT  addresses below this are write-protected (MEM_PROTECT_EN only)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous reset, active low. RAM contents survive it.
//   REQ        in   access request (level)
//   WE         in   1 = write, 0 = read. Sampled with REQ.
//   ADDR       in   word address. Sampled with REQ.
//   WDATA      in   write data. Sampled with REQ.
//   RDATA      out  read data, held until the next read ACK
//   ACK        out  one-cycle completion pulse
//   BUSY       out  high in WAIT, ACK and RECOVER
//   ERR        out  one-cycle pulse with ACK on a rejected write
//   dbg_state  out  current FSM state (0 IDLE, 1 WAIT, 2 ACK, 3 RECOVER)
//
// Build option
//   MEM_PROTECT_EN  When defined, writes with a captured address below
//                   PROT_LIMIT still complete with normal ACK timing. ERR is
//                   raised with ACK and the RAM is left untouched. Reads are
//                   never rejected. When undefined, ERR is constant 0 and all
//                   writes commit.
// -----------------------------------------------------------------------------
module mem_ack_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int PROT_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              BUSY,
    output logic              ERR,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    // Elaboration-time parameter checks. The wait counter is 4 bits wide.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_ack_responder: WAIT_CYCLES must be in 0..15");
    end

    if (PROT_LIMIT < 0) begin : g_bad_prot_limit
        $error("mem_ack_responder: PROT_LIMIT must be non-negative");
    end

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;

    // Request fields captured on entry to WAIT.
    logic                cap_we_q;
    logic [ADDR_W-1:0]   cap_addr_q;
    logic [DATA_W-1:0]   cap_wdata_q;

    logic                capture;     // IDLE edge that accepts a request
    logic                commit;      // WAIT edge that enters ACK
    logic                wr_blocked;  // captured write hits the protected range

    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    // -------------------------------------------------------------------------
    // Write protection
    // -------------------------------------------------------------------------
`ifdef MEM_PROTECT_EN
    assign wr_blocked = cap_we_q && (32'(cap_addr_q) < PROT_LIMIT);
`else
    assign wr_blocked = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        ACK     = 1'b0;
        BUSY    = 1'b0;
        ERR     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                BUSY = 1'b1;
                // A dropped request wins over an expiring counter, so an
                // abort on the last wait edge still suppresses the access.
                if (!REQ) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_ACK: begin
                BUSY    = 1'b1;
                ACK     = 1'b1;
                ERR     = wr_blocked;
                state_d = S_RECOVER;
            end

            S_RECOVER: begin
                // REQ is deliberately not looked at here. This gives the
                // controller one cycle to drop it after seeing ACK.
                BUSY    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter, captured request and read data
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                cap_we_q    <= WE;
                cap_addr_q  <= ADDR;
                cap_wdata_q <= WDATA;
            end
            // RDATA is loaded on the edge entering ACK and then held until
            // the next completed read, so aborted reads leave it untouched.
            if (commit && !cap_we_q) begin
                rdata_q <= mem[cap_addr_q];
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM array. It has no reset, so its contents survive reset_n. The commit
    // term comes from the reset state register, so a write that is pending
    // when reset arrives is never performed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (commit && cap_we_q && !wr_blocked) begin
            mem[cap_addr_q] <= cap_wdata_q;
        end
    end

    assign RDATA     = rdata_q;
    assign dbg_state = state_q;

endmodule
